// File: rtl/ef_smsdac_pkg.sv
// Shared constants for the segmented mismatch-shaping DAC front end.
// Code width, error-register width, midscale code and dither LFSR definition.
package ef_smsdac_pkg;

  localparam int          Q_W       = 9;
  localparam int          LSB_W     = 7;
  localparam logic [8:0]  MIDSCALE  = 9'd256;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [Q_W-1:0]   code_t;
  typedef logic [LSB_W-1:0] err_t;

endpackage

// File: rtl/ef_smsdac_lfsr.sv
// 16-bit right-shifting Galois LFSR used as a dither/selection source.
// Advances on every clock where adv is high; state is exposed directly.
module ef_smsdac_lfsr
  import ef_smsdac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        adv,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (adv) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/ef_smsdac_dsm.sv
// Second-order error-feedback delta-sigma modulator: 16-bit samples in over
// valid/ready, 9-bit DAC code plus random selection bits out every clock.
module ef_smsdac_dsm
  import ef_smsdac_pkg::*;
#(
  parameter int OSR_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        en,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        underrun_clr,
  output logic        underrun,
  output logic [7:0]  x,
  output logic        x_c,
  output logic [6:0]  r
);

  logic [OSR_LOG2-1:0] fcnt_q, fcnt_d;
  logic [15:0]         hold_q, hold_d;
  logic [15:0]         active_q, active_d;
  logic                hold_full_q, hold_full_d;
  logic                underrun_q, underrun_d;
  err_t                e1_q, e1_d;
  err_t                e2_q, e2_d;
  code_t               q_q, q_d;
  logic [6:0]          r_q, r_d;

  logic [15:0] lfsr_state;
  logic        boundary;
  logic        accept;
  logic [15:0] u;
  logic [18:0] v;

  ef_smsdac_lfsr u_lfsr (
    .clk   (clk),
    .rst_b (rst_b),
    .adv   (1'b1),
    .state (lfsr_state)
  );

  assign boundary = &fcnt_q;
  assign accept   = din_valid && !hold_full_q;

  // Handshake, frame counter and hold/active sample registers
  always_comb begin
    fcnt_d      = fcnt_q + OSR_LOG2'(1);
    hold_d      = hold_q;
    active_d    = active_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q;

    if (boundary && hold_full_q) begin
      active_d    = hold_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    if (boundary && !hold_full_q) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  // v is a two's-complement 19-bit sum; bit 18 flags a negative result
  always_comb begin
    u    = {~active_q[15], active_q[14:0]};
    v    = {3'b000, u} + {11'd0, e1_q, 1'b0} - {12'd0, e2_q};
    e2_d = e1_q;
    e1_d = v[LSB_W-1:0];
    if (v[18]) begin
      q_d = '0;
    end else if (|v[17:16]) begin
      q_d = '1;
    end else begin
      q_d = v[15:7];
    end
    r_d = en ? lfsr_state[6:0] : 7'd0;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fcnt_q      <= '0;
      hold_q      <= '0;
      active_q    <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      e1_q        <= '0;
      e2_q        <= '0;
      q_q         <= MIDSCALE;
      r_q         <= '0;
    end else begin
      fcnt_q      <= fcnt_d;
      hold_q      <= hold_d;
      active_q    <= active_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      e1_q        <= e1_d;
      e2_q        <= e2_d;
      q_q         <= q_d;
      r_q         <= r_d;
    end
  end

  assign din_ready = !hold_full_q;
  assign underrun  = underrun_q;
  assign x         = q_q[8:1];
  assign x_c       = q_q[0];
  assign r         = r_q;

endmodule

// File: tb/tb_ef_smsdac_dsm.sv
// Scoreboard bench for ef_smsdac_dsm: stimulus pushes expected per-clock outputs
// from an arithmetic reference model; an independent monitor pops and compares.
module tb_ef_smsdac_dsm;

  localparam int OSR   = 2;
  localparam int FRAME = 1 << OSR;

  logic        clk;
  logic        rst_b;
  logic        en;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        underrun_clr;
  logic        underrun;
  logic [7:0]  x;
  logic        x_c;
  logic [6:0]  r;

  ef_smsdac_dsm #(.OSR_LOG2(OSR)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .en           (en),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .x            (x),
    .x_c          (x_c),
    .r            (r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] x;
    logic       xc;
    logic [6:0] r;
    logic       rdy;
    logic       und;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: plain integers, sample values as signed ints
  int          m_active, m_hold, m_cyc, m_e1, m_e2;
  bit          m_full, m_und;
  int unsigned m_lfsr;

  task automatic chk(input string name, input int cyc, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_hold   = 0;
    m_full   = 1'b0;
    m_und    = 1'b0;
    m_cyc    = 0;
    m_e1     = 0;
    m_e2     = 0;
    m_lfsr   = 32'hACE1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_x"},   -1, int'(x),         8'h80);
    chk({tag, "_xc"},  -1, int'(x_c),       0);
    chk({tag, "_r"},   -1, int'(r),         0);
    chk({tag, "_rdy"}, -1, int'(din_ready), 1);
    chk({tag, "_und"}, -1, int'(underrun),  0);
  endtask

  // Called at posedge+2: drive inputs for the coming edge, predict its result
  task automatic step(input bit valid, input logic [15:0] data, input bit clr, input bit en_i);
    exp_t e;
    int   v, q, err;
    bit   bnd, acc;
    en           = en_i;
    din          = data;
    din_valid    = valid;
    underrun_clr = clr;

    v   = (m_active + 32768) + 2 * m_e1 - m_e2;
    if (v < 0)           q = 0;
    else if (v >= 65536) q = 511;
    else                 q = v / 128;
    err  = ((v % 128) + 128) % 128;
    m_e2 = m_e1;
    m_e1 = err;

    e.r = en_i ? 7'(m_lfsr & 127) : 7'd0;
    if ((m_lfsr & 1) != 0) m_lfsr = (m_lfsr >> 1) ^ 32'hB400;
    else                   m_lfsr = m_lfsr >> 1;

    bnd = (m_cyc % FRAME) == FRAME - 1;
    acc = valid && !m_full;
    if (bnd && !m_full) m_und = 1'b1;
    else if (clr)       m_und = 1'b0;
    if (bnd && m_full) begin
      m_active = m_hold;
      m_full   = 1'b0;
    end
    if (acc) begin
      m_hold = int'($signed(data));
      m_full = 1'b1;
      $display("[TB] cyc=%0d accept din=%04h", m_cyc, data);
    end
    m_cyc++;

    e.x   = 8'(q >> 1);
    e.xc  = 1'(q & 1);
    e.rdy = !m_full;
    e.und = m_und;
    e.cyc = m_cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected record per clock edge, sampled 1 time unit later
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("x",   e.cyc, int'(x),         int'(e.x));
        chk("xc",  e.cyc, int'(x_c),       int'(e.xc));
        chk("r",   e.cyc, int'(r),         int'(e.r));
        chk("rdy", e.cyc, int'(din_ready), int'(e.rdy));
        chk("und", e.cyc, int'(underrun),  int'(e.und));
      end
    end
  end

  initial begin
    rst_b        = 1'b1;
    en           = 1'b0;
    din          = '0;
    din_valid    = 1'b0;
    underrun_clr = 1'b0;
    model_reset();
    #1 rst_b = 1'b0;
    #1;
    check_reset("por");
    @(posedge clk);
    #2;
    rst_b = 1'b1;

    repeat (40) step(1'b1, 16'h0000, 1'b0, 1'b1);
    repeat (40) step(1'b1, 16'h0040, 1'b0, 1'b1);
    repeat (24) step(1'b1, 16'h7FFF, 1'b0, 1'b1);
    repeat (24) step(1'b1, 16'h8000, 1'b0, 1'b1);

    step(1'b1, 16'h1234, 1'b0, 1'b1);
    step(1'b1, 16'h4321, 1'b0, 1'b1);
    repeat (12) step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    repeat (4) step(1'b0, 16'h0000, 1'b0, 1'b1);

    repeat (20) step(1'b1, 16'($urandom), 1'b0, 1'b0);

    repeat (300) step(($urandom % 5) == 0, 16'($urandom), ($urandom % 8) == 0,
                      ($urandom % 4) != 0);

    // Asynchronous reset in the middle of a clock phase
    #3 rst_b = 1'b0;
    #1;
    check_reset("mid");
    model_reset();
    @(posedge clk);
    #2;
    rst_b = 1'b1;
    repeat (40) step(($urandom % 3) == 0, 16'($urandom), 1'b0, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
